cpu_axi_bridge: RTL and testbench

Uncached bridge directly downstream of the `mips` core. It converts the core's SRAM-like instruction and data ports into single-beat transactions on one AXI3 master port. It drives the core's `stall_from_cache` input until every request of the current pipeline cycle has completed, and it returns read data on `inst_sram_rdata` / `data_sram_rdata`. Address translation (0xbfaf→0x1faf) is already done inside the core, so the bridge passes addresses through unchanged.

---
 rtl/bridge_pkg.sv | 27 ++
 rtl/axi_size_enc.sv | 23 ++
 rtl/cpu_axi_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the uncached CPU-to-AXI3 bridge.
// Holds the bridge FSM state encoding, the fixed AXI field values used on
// every single-beat transaction, and a word-alignment helper for read addresses.
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D_AR = 3'd1,
        D_R  = 3'd2,
        D_W  = 3'd3,
        D_B  = 3'd4,
        I_AR = 3'd5,
        I_R  = 3'd6,
        DONE = 3'd7
    } state_t;

    localparam logic [1:0] BURST_INCR     = 2'b01;
    localparam logic [3:0] LEN_SINGLE     = 4'd0;
    localparam logic [2:0] SIZE_WORD      = 3'd2;
    localparam logic [3:0] AXI_ID_DEFAULT = 4'd0;

    // Reads always fetch a whole word, so the byte offset is dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/axi_size_enc.sv
// Combinational AXI transfer-size encoder for stores.
// Ports:
//   wen  (in, 4)  byte strobes of the store
//   size (out, 3) AXI awsize: 0 for single byte, 1 for aligned halfword,
//                 2 for every other strobe pattern
module axi_size_enc
    import bridge_pkg::*;
(
    input  logic [3:0] wen,
    output logic [2:0] size
);

    // Strobe pattern to transfer size; irregular patterns fall back to a word.
    always_comb begin
        size = SIZE_WORD;
        case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'd0;
            4'b0011, 4'b1100:                   size = 3'd1;
            default:                            size = SIZE_WORD;
        endcase
    end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Uncached bridge between the core's SRAM-like instruction/data ports and a
// single AXI3 master port. One transaction is outstanding at a time; data is
// served before instruction because the memory stage is the older request.
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   inst_sram_*                     instruction fetch request / registered read word
//   data_sram_*                     load/store request / registered load word
//   stall                           holds the core until the current cycle's requests finish
//   ar*/r*/aw*/w*/b*                AXI3 master channels (single-beat, fixed ID)
module cpu_axi_bridge
    import bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stall,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_t      state_r, next_state_s;
    logic        aw_done_r, w_done_r;
    logic [31:0] inst_rdata_r, data_rdata_r;
    logic        aw_hs_s, w_hs_s;
    logic        unused_s;

    // Responses are assumed OKAY and single-beat, so these fields carry no information.
    assign unused_s = ^{rid, rresp, rlast, bid, bresp};

    // Channel valid/ready are decoded straight from the state and done flags.
    assign arvalid = (state_r == D_AR) || (state_r == I_AR);
    assign rready  = (state_r == D_R)  || (state_r == I_R);
    assign awvalid = (state_r == D_W) && !aw_done_r;
    assign wvalid  = (state_r == D_W) && !w_done_r;
    assign bready  = (state_r == D_B);
    assign aw_hs_s = awvalid && awready;
    assign w_hs_s  = wvalid && wready;

    assign stall = resetn && (state_r != DONE) && (inst_sram_en || data_sram_en);

    // Fixed single-beat AXI fields.
    assign arid    = AXI_ID;
    assign arlen   = LEN_SINGLE;
    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = AXI_ID;
    assign awlen   = LEN_SINGLE;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = AXI_ID;
    assign wlast   = 1'b1;

    // Write fields come from the live request, which the core holds during stall.
    assign awaddr = data_sram_addr;
    assign wdata  = data_sram_wdata;
    assign wstrb  = data_sram_wen;

    assign inst_sram_rdata = inst_rdata_r;
    assign data_sram_rdata = data_rdata_r;

    axi_size_enc u_size_enc (
        .wen  (data_sram_wen),
        .size (awsize)
    );

    // Read address selects the requester that owns the current AR phase.
    always_comb begin
        araddr = align_word(data_sram_addr);
        if (state_r == I_AR) begin
            araddr = align_word(inst_sram_addr);
        end else begin
            araddr = align_word(data_sram_addr);
        end
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (data_sram_en && (data_sram_wen == 4'd0)) begin
                    next_state_s = D_AR;
                end else if (data_sram_en) begin
                    next_state_s = D_W;
                end else if (inst_sram_en) begin
                    next_state_s = I_AR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            D_AR: begin
                if (arready) next_state_s = D_R;
                else         next_state_s = D_AR;
            end
            D_R: begin
                if (rvalid && inst_sram_en) next_state_s = I_AR;
                else if (rvalid)            next_state_s = DONE;
                else                        next_state_s = D_R;
            end
            D_W: begin
                // Each channel may finish in an earlier cycle or in this one.
                if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) next_state_s = D_B;
                else                                                next_state_s = D_W;
            end
            D_B: begin
                if (bvalid && inst_sram_en) next_state_s = I_AR;
                else if (bvalid)            next_state_s = DONE;
                else                        next_state_s = D_B;
            end
            I_AR: begin
                if (arready) next_state_s = I_R;
                else         next_state_s = I_AR;
            end
            I_R: begin
                if (rvalid) next_state_s = DONE;
                else        next_state_s = I_R;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_r <= IDLE;
        else         state_r <= next_state_s;
    end

    // Per-channel completion flags for the write address and write data phases.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else if (state_r == D_W) begin
            aw_done_r <= aw_done_r || aw_hs_s;
            w_done_r  <= w_done_r || w_hs_s;
        end else begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end
    end

    // Read-data capture; each register holds until its next read completes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_rdata_r <= 32'd0;
            data_rdata_r <= 32'd0;
        end else begin
            if ((state_r == D_R) && rvalid) data_rdata_r <= rdata;
            if ((state_r == I_R) && rvalid) inst_rdata_r <= rdata;
        end
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stall;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int failures = 0;

    // slave configuration and state
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] s_rdata_q[$];

    // monitor logs
    logic [31:0] ar_addr_q[$];
    logic [2:0]  ar_size_q[$];
    logic [31:0] aw_addr_q[$];
    logic [2:0]  aw_size_q[$];
    logic [31:0] w_data_q[$];
    logic [3:0]  w_strb_q[$];
    int ar_fixed_bad = 0, w_fixed_bad = 0;
    int ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
    int awv_cycles = 0, wv_cycles = 0;

    // scoreboards
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_data_q[$];
    logic [67:0] exp_wr_q[$];

    cpu_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata), .stall(stall),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // AXI slave: drives its signals on the falling edge with programmable waits
    always @(negedge clk) begin
        rid = 4'd0; bid = 4'd0; rresp = 2'b00; bresp = 2'b00; rlast = 1'b1;
        if (!resetn) begin
            arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            rdata = 32'd0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (arvalid) begin
                if (ar_cnt >= ar_delay) arready = 1'b1;
                else begin arready = 1'b0; ar_cnt++; end
            end else begin arready = 1'b0; ar_cnt = 0; end
            if (awvalid) begin
                if (aw_cnt >= aw_delay) awready = 1'b1;
                else begin awready = 1'b0; aw_cnt++; end
            end else begin awready = 1'b0; aw_cnt = 0; end
            if (wvalid) begin
                if (w_cnt >= w_delay) wready = 1'b1;
                else begin wready = 1'b0; w_cnt++; end
            end else begin wready = 1'b0; w_cnt = 0; end
            if (rready && s_rdata_q.size() > 0) begin
                if (r_cnt >= r_delay) begin rvalid = 1'b1; rdata = s_rdata_q[0]; end
                else begin rvalid = 1'b0; r_cnt++; end
            end else begin rvalid = 1'b0; r_cnt = 0; end
            if (bready) begin
                if (b_cnt >= b_delay) bvalid = 1'b1;
                else begin bvalid = 1'b0; b_cnt++; end
            end else begin bvalid = 1'b0; b_cnt = 0; end
        end
    end

    // Bus monitor: records handshakes and valid durations at the rising edge
    always @(posedge clk) begin
        if (resetn) begin
            if (awvalid) awv_cycles++;
            if (wvalid)  wv_cycles++;
            if (arvalid && arready) begin
                ar_hs_n++;
                ar_addr_q.push_back(araddr);
                ar_size_q.push_back(arsize);
                if (arlen !== 4'd0 || arburst !== 2'b01 || arid !== 4'd0 || arlock !== 2'b00 ||
                    arcache !== 4'd0 || arprot !== 3'd0) ar_fixed_bad++;
            end
            if (rvalid && rready && s_rdata_q.size() > 0) void'(s_rdata_q.pop_front());
            if (awvalid && awready) begin
                aw_hs_n++;
                aw_addr_q.push_back(awaddr);
                aw_size_q.push_back(awsize);
                if (awlen !== 4'd0 || awburst !== 2'b01 || awid !== 4'd0) w_fixed_bad++;
            end
            if (wvalid && wready) begin
                w_hs_n++;
                w_data_q.push_back(wdata);
                w_strb_q.push_back(wstrb);
                if (wlast !== 1'b1 || wid !== 4'd0) w_fixed_bad++;
            end
            if (bvalid && bready) b_hs_n++;
        end
    end

    task automatic clear_logs();
        ar_addr_q.delete(); ar_size_q.delete(); aw_addr_q.delete(); aw_size_q.delete();
        w_data_q.delete(); w_strb_q.delete();
        ar_hs_n = 0; aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; awv_cycles = 0; wv_cycles = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00000;
        data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b want=0", stall); end
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready} !== 5'd0) begin
            failures++; $display("FAIL reset_valids got=%b want=00000", {arvalid, rready, awvalid, wvalid, bready});
        end
        checks++;
        if (inst_sram_rdata !== 32'd0 || data_sram_rdata !== 32'd0) begin
            failures++; $display("FAIL reset_rdata got=%h/%h want=0/0", inst_sram_rdata, data_sram_rdata);
        end
        inst_sram_en = 1'b0; data_sram_en = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch(input logic [31:0] addr, input logic [31:0] word);
        int cyc;
        logic [31:0] exp;
        clear_logs();
        s_rdata_q.push_back(word);
        exp_inst_q.push_back(word);
        inst_sram_en = 1'b1; inst_sram_addr = addr;
        #1;
        cyc = 0;
        while (stall && cyc < 40) begin cyc++; @(posedge clk); #1; end
        checks++;
        if (cyc !== 3) begin failures++; $display("FAIL fetch_stall_cycles got=%0d want=3", cyc); end
        checks++;
        if (ar_addr_q.size() !== 1 || ar_addr_q[0] !== {addr[31:2], 2'b00}) begin
            failures++; $display("FAIL fetch_araddr n=%0d got=%h want=%h", ar_addr_q.size(),
                                 (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hx, {addr[31:2], 2'b00});
        end
        checks++;
        if (ar_size_q.size() !== 1 || ar_size_q[0] !== 3'd2 || ar_fixed_bad !== 0) begin
            failures++; $display("FAIL fetch_arfields n=%0d bad=%0d want size=2 bad=0", ar_size_q.size(), ar_fixed_bad);
        end
        exp = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hx;
        checks++;
        if (inst_sram_rdata !== exp) begin failures++; $display("FAIL fetch_rdata got=%h want=%h", inst_sram_rdata, exp); end
        inst_sram_en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (stall !== 1'b0 || inst_sram_rdata !== exp) begin
            failures++; $display("FAIL fetch_hold stall=%0b rdata=%h want 0/%h", stall, inst_sram_rdata, exp);
        end
    endtask

    task automatic test_load_fetch();
        int cyc;
        logic [31:0] exp_d, exp_i;
        clear_logs();
        s_rdata_q.push_back(32'h11223344); exp_data_q.push_back(32'h11223344);
        s_rdata_q.push_back(32'h24020005); exp_inst_q.push_back(32'h24020005);
        data_sram_en = 1'b1; data_sram_wen = 4'd0; data_sram_addr = 32'h1faf0006;
        inst_sram_en = 1'b1; inst_sram_addr = 32'hbfc00004;
        #1;
        cyc = 0;
        while (stall && cyc < 40) begin cyc++; @(posedge clk); #1; end
        checks++;
        if (cyc !== 5) begin failures++; $display("FAIL loadfetch_stall_cycles got=%0d want=5", cyc); end
        checks++;
        if (ar_addr_q.size() !== 2 || ar_addr_q[0] !== 32'h1faf0004 || ar_addr_q[1] !== 32'hbfc00004) begin
            failures++; $display("FAIL loadfetch_ar_order n=%0d want 1faf0004 then bfc00004", ar_addr_q.size());
        end
        exp_d = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 32'hx;
        exp_i = (exp_inst_q.size() > 0) ? exp_inst_q.pop_front() : 32'hx;
        checks++;
        if (data_sram_rdata !== exp_d) begin failures++; $display("FAIL loadfetch_drdata got=%h want=%h", data_sram_rdata, exp_d); end
        checks++;
        if (inst_sram_rdata !== exp_i) begin failures++; $display("FAIL loadfetch_irdata got=%h want=%h", inst_sram_rdata, exp_i); end
        data_sram_en = 1'b0; inst_sram_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                              input int awd, input int wdl, input int bd, input logic [2:0] exp_size);
        int cyc, exp_cyc;
        logic [67:0] exp;
        clear_logs();
        aw_delay = awd; w_delay = wdl; b_delay = bd;
        exp_wr_q.push_back({addr, wd, wen});
        exp_cyc = 1 + ((awd > wdl) ? awd : wdl) + 1 + bd + 1;
        data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wd;
        #1;
        cyc = 0;
        while (stall && cyc < 60) begin cyc++; @(posedge clk); #1; end
        checks++;
        if (cyc !== exp_cyc) begin failures++; $display("FAIL store_stall_cycles wen=%b got=%0d want=%0d", wen, cyc, exp_cyc); end
        checks++;
        if (aw_hs_n !== 1 || w_hs_n !== 1 || b_hs_n !== 1) begin
            failures++; $display("FAIL store_handshakes got aw=%0d w=%0d b=%0d want 1/1/1", aw_hs_n, w_hs_n, b_hs_n);
        end
        checks++;
        if (awv_cycles !== awd + 1 || wv_cycles !== wdl + 1) begin
            failures++; $display("FAIL store_valid_len got aw=%0d w=%0d want %0d/%0d", awv_cycles, wv_cycles, awd + 1, wdl + 1);
        end
        checks++;
        if (aw_size_q.size() !== 1 || aw_size_q[0] !== exp_size) begin
            failures++; $display("FAIL store_awsize wen=%b got=%0d want=%0d", wen,
                                 (aw_size_q.size() > 0) ? aw_size_q[0] : 3'bx, exp_size);
        end
        exp = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : 68'hx;
        checks++;
        if (aw_addr_q.size() !== 1 || w_data_q.size() !== 1 ||
            {aw_addr_q[0], w_data_q[0], w_strb_q[0]} !== exp || w_fixed_bad !== 0) begin
            failures++; $display("FAIL store_fields want addr=%h data=%h strb=%b bad=%0d", exp[67:36], exp[35:4], exp[3:0], w_fixed_bad);
        end
        data_sram_en = 1'b0; data_sram_wen = 4'd0;
        aw_delay = 0; w_delay = 0; b_delay = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle();
        int bad = 0;
        clear_logs();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (stall !== 1'b0 || {arvalid, awvalid, wvalid} !== 3'd0) begin
                failures++; bad++;
                $display("FAIL idle_cycle%0d stall=%0b valids=%b want 0/000", i, stall, {arvalid, awvalid, wvalid});
            end
        end
        checks++;
        if (ar_hs_n + aw_hs_n + w_hs_n !== 0) begin failures++; $display("FAIL idle_traffic got=%0d want=0", ar_hs_n + aw_hs_n + w_hs_n); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        clear_logs();
        r_delay = 50;
        s_rdata_q.push_back(32'h00000055);
        inst_sram_en = 1'b1; inst_sram_addr = 32'h00400000;
        #1;
        cyc = 0;
        while (!rready && cyc < 20) begin cyc++; @(posedge clk); #1; end
        checks++;
        if (rready !== 1'b1) begin failures++; $display("FAIL rstmid_reach_r got=%0b want=1", rready); end
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready} !== 5'd0 || stall !== 1'b0) begin
            failures++; $display("FAIL rstmid_outputs valids=%b stall=%0b want 00000/0", {arvalid, rready, awvalid, wvalid, bready}, stall);
        end
        checks++;
        if (inst_sram_rdata !== 32'd0 || data_sram_rdata !== 32'd0) begin
            failures++; $display("FAIL rstmid_rdata got=%h/%h want=0/0", inst_sram_rdata, data_sram_rdata);
        end
        s_rdata_q.delete();
        r_delay = 0;
        inst_sram_en = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (stall !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0) begin
            failures++; $display("FAIL rstmid_idle stall=%0b arvalid=%0b rready=%0b want 0/0/0", stall, arvalid, rready);
        end
        test_fetch(32'hbfc00010, 32'h8fbf0010);
    endtask

    initial begin
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rdata = 32'd0; rid = 4'd0; bid = 4'd0; rresp = 2'b00; bresp = 2'b00; rlast = 1'b1;
        test_reset();
        test_fetch(32'hbfc00000, 32'h3c1d0001);
        test_load_fetch();
        test_store(4'b0100, 32'h00000012, 32'h00ab0000, 3, 0, 0, 3'd0);
        test_idle();
        test_store(4'b1111, 32'h00001000, 32'hdeadbeef, 0, 0, 5, 3'd2);
        test_store(4'b0011, 32'h00000020, 32'h0000beef, 0, 2, 1, 3'd1);
        test_store(4'b1100, 32'h00000022, 32'hcafe0000, 1, 1, 0, 3'd1);
        test_store(4'b0111, 32'h00000030, 32'h00123456, 0, 0, 0, 3'd2);
        test_store(4'b1000, 32'h00000043, 32'h7f000000, 0, 0, 0, 3'd0);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
